// File: rtl/exec_mem_stage.sv
// RV32I single-cycle decode/execute/memory slice: combinational decode, ALU,
// branch resolution and load path, plus a byte-lane data memory written on clk.
module exec_mem_stage #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic        regwrite,
  output logic [31:0] rd_data,
  output logic        jump,
  output logic [31:0] jump_target
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] pc_plus4;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign rd_addr  = instr[11:7];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign pc_plus4 = pc + 32'd4;

  logic is_op;
  logic is_store;
  assign is_op    = (opcode == OPC_OP);
  assign is_store = (opcode == OPC_STORE);

  // ALU shared by OP and OP-IMM
  logic [31:0] op2;
  logic [4:0]  shamt;
  logic [31:0] alu_result;

  assign op2   = is_op ? rs2_data : imm_i;
  assign shamt = op2[4:0];

  always_comb begin
    alu_result = 32'd0;
    case (funct3)
      3'b000: alu_result = (is_op && instr[30]) ? (rs1_data - op2) : (rs1_data + op2);
      3'b001: alu_result = rs1_data << shamt;
      3'b010: alu_result = {31'd0, $signed(rs1_data) < $signed(op2)};
      3'b011: alu_result = {31'd0, rs1_data < op2};
      3'b100: alu_result = rs1_data ^ op2;
      3'b101: alu_result = instr[30] ? $unsigned($signed(rs1_data) >>> shamt)
                                     : (rs1_data >> shamt);
      3'b110: alu_result = rs1_data | op2;
      default: alu_result = rs1_data & op2;
    endcase
  end

  logic branch_valid;
  logic branch_taken;

  always_comb begin
    branch_valid = 1'b1;
    branch_taken = 1'b0;
    case (funct3)
      3'b000: branch_taken = (rs1_data == rs2_data);
      3'b001: branch_taken = (rs1_data != rs2_data);
      3'b100: branch_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101: branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110: branch_taken = (rs1_data <  rs2_data);
      3'b111: branch_taken = (rs1_data >= rs2_data);
      default: branch_valid = 1'b0;
    endcase
  end

  // Addresses wrap modulo DEPTH*4: bits above the word index are dropped
  logic [31:0]   mem_addr;
  logic [AW-1:0] word_idx;
  logic [31:0]   rdata_word;
  logic          unused_addr_bits;

  assign mem_addr         = rs1_data + (is_store ? imm_s : imm_i);
  assign word_idx         = mem_addr[AW+1:2];
  assign unused_addr_bits = &{1'b0, mem_addr[31:AW+2]};

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic        load_valid;

  always_comb begin
    case (mem_addr[1:0])
      2'b00:   load_byte = rdata_word[7:0];
      2'b01:   load_byte = rdata_word[15:8];
      2'b10:   load_byte = rdata_word[23:16];
      default: load_byte = rdata_word[31:24];
    endcase
  end

  assign load_half = mem_addr[1] ? rdata_word[31:16] : rdata_word[15:0];

  always_comb begin
    load_valid = 1'b1;
    load_data  = 32'd0;
    case (funct3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b010:  load_data = rdata_word;
      3'b100:  load_data = {24'd0, load_byte};
      3'b101:  load_data = {16'd0, load_half};
      default: load_valid = 1'b0;
    endcase
  end

  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [3:0]  lane_we;

  always_comb begin
    store_be    = 4'b0000;
    store_wdata = rs2_data;
    case (funct3)
      3'b000: begin
        store_be    = 4'b0001 << mem_addr[1:0];
        store_wdata = {4{rs2_data[7:0]}};
      end
      3'b001: begin
        store_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{rs2_data[15:0]}};
      end
      3'b010: store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  end

  assign lane_we = (is_store && !reset) ? store_be : 4'b0000;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 8'd0;
          end
        end else if (lane_we[gi]) begin
          mem[word_idx] <= store_wdata[8*gi +: 8];
        end
      end

      assign rdata_word[8*gi +: 8] = mem[word_idx];
    end
  endgenerate

  logic wb_enable;

  always_comb begin
    wb_enable   = 1'b0;
    rd_data     = alu_result;
    jump        = 1'b0;
    jump_target = pc_plus4;
    case (opcode)
      OPC_OP, OPC_OPIMM: wb_enable = 1'b1;
      OPC_LUI: begin
        wb_enable = 1'b1;
        rd_data   = imm_u;
      end
      OPC_AUIPC: begin
        wb_enable = 1'b1;
        rd_data   = pc + imm_u;
      end
      OPC_JAL: begin
        wb_enable   = 1'b1;
        rd_data     = pc_plus4;
        jump        = 1'b1;
        jump_target = pc + imm_j;
      end
      OPC_JALR: begin
        wb_enable   = 1'b1;
        rd_data     = pc_plus4;
        jump        = 1'b1;
        jump_target = (rs1_data + imm_i) & 32'hFFFF_FFFE;
      end
      OPC_BRANCH: begin
        jump        = branch_valid && branch_taken;
        jump_target = pc + imm_b;
      end
      OPC_LOAD: begin
        wb_enable = load_valid;
        rd_data   = load_data;
      end
      default: wb_enable = 1'b0;
    endcase
  end

  assign regwrite = wb_enable && (rd_addr != 5'd0);

endmodule

// File: tb/tb_exec_mem_stage.sv
// Self-checking bench for exec_mem_stage: directed cases from the RV32I rules
// followed by randomized ALU, branch and memory traffic against a byte-array model.
module tb_exec_mem_stage;
  localparam int DEPTH = 64;
  localparam int MB    = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        regwrite, jump;
  logic [31:0] rd_data, jump_target;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem_model [MB];

  always #5 clk = ~clk;

  exec_mem_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .regwrite(regwrite), .rd_data(rd_data),
    .jump(jump), .jump_target(jump_target)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, r2, r1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, r1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3);
    return {imm[11:5], r2, r1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3);
    return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic ref_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      default: return a >= b;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
    int a, h, w;
    a = int'(addr % MB);
    h = a - (a % 2);
    w = a - (a % 4);
    case (f3)
      3'd0: return {{24{mem_model[a][7]}}, mem_model[a]};
      3'd1: return {{16{mem_model[h+1][7]}}, mem_model[h+1], mem_model[h]};
      3'd2: return {mem_model[w+3], mem_model[w+2], mem_model[w+1], mem_model[w]};
      3'd4: return {24'd0, mem_model[a]};
      default: return {16'd0, mem_model[h+1], mem_model[h]};
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] d);
    int a, h, w;
    a = int'(addr % MB);
    h = a - (a % 2);
    w = a - (a % 4);
    case (f3)
      3'd0: mem_model[a] = d[7:0];
      3'd1: begin mem_model[h] = d[7:0]; mem_model[h+1] = d[15:8]; end
      default: for (int k = 0; k < 4; k++) mem_model[w+k] = d[8*k +: 8];
    endcase
  endtask

  task automatic clear_model();
    for (int k = 0; k < MB; k++) mem_model[k] = 8'd0;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    instr = i; pc = p; rs1_data = a; rs2_data = b;
    #1;
    $display("txn instr=%08h pc=%08h rs1=%08h rs2=%08h rd=%0d we=%0b wb=%08h j=%0b tgt=%08h",
             i, p, a, b, rd_addr, regwrite, rd_data, jump, jump_target);
  endtask

  task automatic do_load(input string tag, input logic [4:0] rd, input logic [31:0] base,
                         input logic [11:0] imm, input logic [2:0] f3);
    logic [31:0] addr;
    addr = base + sext12(imm);
    drive(enc_i(imm, 5'd1, f3, rd, 7'h03), 32'h200, base, 32'h0);
    check({tag, "_data"}, rd_data, ref_load(addr, f3));
    check({tag, "_we"}, {31'd0, regwrite}, {31'd0, rd != 5'd0});
    check({tag, "_jump"}, {31'd0, jump}, 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [31:0] base, input logic [11:0] imm,
                          input logic [2:0] f3, input logic [31:0] d);
    drive(enc_s(imm, 5'd2, 5'd1, f3), 32'h300, base, d);
    check({tag, "_we"}, {31'd0, regwrite}, 32'd0);
    check({tag, "_tgt"}, jump_target, 32'h304);
    if (!reset) ref_store(base + sext12(imm), f3, d);
  endtask

  initial begin
    logic [31:0] a, b, p, ins, imm32;
    logic [11:0] imm;
    logic [12:0] boff;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        alt;
    int          kind, sel;

    reset = 1'b1;
    instr = 32'hFFFF_FFFF; pc = 0; rs1_data = 0; rs2_data = 0;
    clear_model();

    // Outputs keep following inputs while reset is held
    drive(32'hFFB0_0093, 32'h0, 32'h0, 32'h0);
    check("addi_in_reset", rd_data, 32'hFFFF_FFFB);
    @(negedge clk);
    reset = 1'b0;
    instr = 32'hFFFF_FFFF;

    drive(32'hFFB0_0093, 32'h80, 32'h0, 32'h0);
    check("addi_rd", {27'd0, rd_addr}, 32'd1);
    check("addi_we", {31'd0, regwrite}, 32'd1);
    check("addi_data", rd_data, 32'hFFFF_FFFB);
    check("addi_jump", {31'd0, jump}, 32'd0);
    check("addi_tgt", jump_target, 32'h84);

    drive(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h0, 32'h8000_0000, 32'h1);
    check("sub", rd_data, 32'h7FFF_FFFF);
    drive(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3, 7'h33), 32'h0, 32'h8000_0000, 32'h1);
    check("slt", rd_data, 32'h1);
    drive(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd3, 7'h33), 32'h0, 32'h8000_0000, 32'h1);
    check("sltu", rd_data, 32'h0);
    drive(enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3, 7'h33), 32'h0, 32'h8000_0000, 32'h1);
    check("sra", rd_data, 32'hC000_0000);

    do_load("lw_after_reset", 5'd3, 32'h10, 12'h0, 3'd2);
    check("lw_after_reset_zero", rd_data, 32'h0);
    do_store("sw", 32'h10, 12'h0, 3'd2, 32'h1234_5678);
    do_store("sb", 32'h10, 12'h1, 3'd0, 32'h0000_00AB);
    do_load("lw", 5'd3, 32'h10, 12'h0, 3'd2);
    check("lw_value", rd_data, 32'h1234_AB78);
    do_load("lb", 5'd3, 32'h10, 12'h1, 3'd0);
    check("lb_value", rd_data, 32'hFFFF_FFAB);
    do_load("lbu", 5'd3, 32'h10, 12'h1, 3'd4);
    check("lbu_value", rd_data, 32'h0000_00AB);
    do_load("lhu", 5'd3, 32'h10, 12'h2, 3'd5);
    check("lhu_value", rd_data, 32'h0000_1234);
    do_load("lw_wrap", 5'd3, 32'h10 + MB, 12'h0, 3'd2);
    check("lw_wrap_value", rd_data, 32'h1234_AB78);

    drive(enc_b(13'd8, 5'd2, 5'd1, 3'd0), 32'h100, 32'h5, 32'h5);
    check("beq_jump", {31'd0, jump}, 32'd1);
    check("beq_tgt", jump_target, 32'h108);
    drive(enc_b(13'd8, 5'd2, 5'd1, 3'd1), 32'h100, 32'h5, 32'h5);
    check("bne_jump", {31'd0, jump}, 32'd0);
    drive(enc_b(13'd8, 5'd2, 5'd1, 3'd6), 32'h100, 32'hFFFF_FFFF, 32'h1);
    check("bltu_jump", {31'd0, jump}, 32'd0);
    drive(enc_b(13'd8, 5'd2, 5'd1, 3'd4), 32'h100, 32'hFFFF_FFFF, 32'h1);
    check("blt_jump", {31'd0, jump}, 32'd1);
    check("branch_we", {31'd0, regwrite}, 32'd0);

    drive(enc_i(12'd4, 5'd5, 3'd0, 5'd1, 7'h67), 32'h40, 32'h203, 32'h0);
    check("jalr_jump", {31'd0, jump}, 32'd1);
    check("jalr_tgt", jump_target, 32'h206);
    check("jalr_data", rd_data, 32'h44);
    check("jalr_we", {31'd0, regwrite}, 32'd1);

    drive(enc_j(21'h800, 5'd1), 32'h1000, 32'h0, 32'h0);
    check("jal_tgt", jump_target, 32'h1800);
    check("jal_data", rd_data, 32'h1004);
    drive(enc_j(-21'sd8, 5'd1), 32'h1000, 32'h0, 32'h0);
    check("jal_neg_tgt", jump_target, 32'h0FF8);
    drive({20'h12345, 5'd4, 7'h37}, 32'h1000, 32'h0, 32'h0);
    check("lui", rd_data, 32'h1234_5000);
    drive({20'h12345, 5'd4, 7'h17}, 32'h1000, 32'h0, 32'h0);
    check("auipc", rd_data, 32'h1234_6000);

    drive(32'hFFB0_0013, 32'h80, 32'h0, 32'h0);
    check("addi_x0_we", {31'd0, regwrite}, 32'd0);
    drive(32'hFFFF_FFFF, 32'h80, 32'h10, 32'hCAFE_F00D);
    check("bad_op_we", {31'd0, regwrite}, 32'd0);
    check("bad_op_jump", {31'd0, jump}, 32'd0);
    check("bad_op_tgt", jump_target, 32'h84);
    do_load("lw_after_bad_op", 5'd3, 32'h10, 12'h0, 3'd2);

    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 4));
      a = $urandom(); b = $urandom();
      p = $urandom() & 32'hFFFF_FFFC;
      rd = 5'($urandom());
      f3 = 3'($urandom());
      alt = 1'($urandom());
      imm = 12'($urandom());
      case (kind)
        0: begin
          if (f3 != 3'd0 && f3 != 3'd5) alt = 1'b0;
          drive(enc_r({1'b0, alt, 5'd0}, 5'd2, 5'd1, f3, rd, 7'h33), p, a, b);
          check("rnd_op", rd_data, ref_alu(f3, alt, a, b));
          check("rnd_op_we", {31'd0, regwrite}, {31'd0, rd != 5'd0});
          check("rnd_op_tgt", jump_target, p + 32'd4);
        end
        1: begin
          if (f3 == 3'd1) imm = {7'd0, imm[4:0]};
          if (f3 == 3'd5) imm = {1'b0, alt, 5'd0, imm[4:0]};
          imm32 = sext12(imm);
          ins = enc_i(imm, 5'd1, f3, rd, 7'h13);
          drive(ins, p, a, b);
          check("rnd_opimm", rd_data, ref_alu(f3, (f3 == 3'd5) && alt, a, imm32));
          check("rnd_opimm_we", {31'd0, regwrite}, {31'd0, rd != 5'd0});
          check("rnd_opimm_jump", {31'd0, jump}, 32'd0);
        end
        2: begin
          sel = int'($urandom_range(0, 2));
          do_store("rnd_st", a, imm, 3'(sel), b);
        end
        3: begin
          sel = int'($urandom_range(0, 4));
          case (sel)
            0: f3 = 3'd0;
            1: f3 = 3'd1;
            2: f3 = 3'd2;
            3: f3 = 3'd4;
            default: f3 = 3'd5;
          endcase
          do_load("rnd_ld", rd, a, imm, f3);
        end
        default: begin
          sel = int'($urandom_range(0, 5));
          f3 = (sel < 2) ? 3'(sel) : 3'(sel + 2);
          if ($urandom_range(0, 3) == 0) b = a;
          boff = {12'($urandom()), 1'b0};
          drive(enc_b(boff, 5'd2, 5'd1, f3), p, a, b);
          check("rnd_br_jump", {31'd0, jump}, {31'd0, ref_branch(f3, a, b)});
          check("rnd_br_tgt", jump_target, p + {{19{boff[12]}}, boff});
          check("rnd_br_we", {31'd0, regwrite}, 32'd0);
        end
      endcase
    end

    // A store presented during reset must not survive; reset wipes everything
    @(negedge clk);
    reset = 1'b1;
    do_store("sw_in_reset", 32'h20, 12'h0, 3'd2, 32'hDEAD_BEEF);
    @(negedge clk);
    reset = 1'b0;
    instr = 32'hFFFF_FFFF;
    clear_model();
    do_load("lw_reset_store", 5'd3, 32'h20, 12'h0, 3'd2);
    check("lw_reset_store_zero", rd_data, 32'h0);
    do_load("lw_reset_cleared", 5'd3, 32'h10, 12'h0, 3'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
